// File: rtl/ir_frame_encoder.sv
// ir_frame_encoder: drives a parallel-load shift register and turns its serial
// output into a pulse-width-coded IR frame (start mark, spaced data marks, gap),
// producing both the raw envelope and the carrier-modulated LED drive.
module ir_frame_encoder #(
    parameter int unsigned N            = 12,
    parameter int unsigned UNIT_CYCLES  = 30000,
    parameter int unsigned CARRIER_HALF = 625,
    parameter int unsigned GAP_UNITS    = 75
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_start,
    input  logic [N-1:0] i_code,
    input  logic         i_sr_sout,
    output logic [N-1:0] o_sr_pin,
    output logic         o_sr_load,
    output logic         o_sr_enable,
    output logic         o_envelope,
    output logic         o_ir,
    output logic         o_busy,
    output logic         o_done
);

    localparam int unsigned UC_W      = $clog2(UNIT_CYCLES);
    localparam int unsigned MAX_UNITS = (GAP_UNITS > 4) ? GAP_UNITS : 4;
    localparam int unsigned UN_W      = $clog2(MAX_UNITS);
    localparam int unsigned BC_W      = $clog2(N + 1);
    localparam int unsigned CC_W      = $clog2(CARRIER_HALF + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SPACE,
        S_MARK,
        S_GAP
    } state_t;

    state_t          r_state;
    logic [UC_W-1:0] r_unit_cyc;
    logic [UN_W-1:0] r_units;
    logic [BC_W-1:0] r_bit_cnt;
    logic            r_bit;
    logic [CC_W-1:0] r_car_cnt;
    logic            r_car_phase;
    logic            r_done;

    logic            w_tick;
    logic [UN_W-1:0] w_last_idx;
    logic            w_state_end;
    logic            w_accept;
    logic            w_fetch;
    logic            w_in_mark;

    // Index of the final unit of the current state; data marks stretch to two units for a 1.
    always_comb begin
        w_last_idx = '0;
        case (r_state)
            S_START: w_last_idx = UN_W'(3);
            S_MARK:  w_last_idx = r_bit ? UN_W'(1) : UN_W'(0);
            S_GAP:   w_last_idx = UN_W'(GAP_UNITS - 1);
            default: w_last_idx = '0;
        endcase
    end

    assign w_tick      = (r_unit_cyc == UC_W'(UNIT_CYCLES - 1));
    assign w_state_end = w_tick && (r_units == w_last_idx);
    assign w_accept    = (r_state == S_IDLE) && i_start;
    assign w_fetch     = (r_state == S_SPACE) && w_state_end && (r_bit_cnt != BC_W'(N));
    assign w_in_mark   = (r_state == S_START) || (r_state == S_MARK);

    // Shift register control is combinational so load/shift land on the same edge as the decision.
    assign o_sr_pin    = i_code;
    assign o_sr_load   = w_accept;
    assign o_sr_enable = w_accept || w_fetch;

    assign o_envelope  = w_in_mark;
    assign o_ir        = w_in_mark && r_car_phase;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;

    // Frame sequencer: state, unit timing, bit capture, carrier and done pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_unit_cyc  <= '0;
            r_units     <= '0;
            r_bit_cnt   <= '0;
            r_bit       <= 1'b0;
            r_car_cnt   <= '0;
            r_car_phase <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Carrier free-runs only inside a mark; parked at phase high so each mark starts high.
            if (w_in_mark) begin
                if (r_car_cnt == CC_W'(CARRIER_HALF - 1)) begin
                    r_car_cnt   <= '0;
                    r_car_phase <= ~r_car_phase;
                end else begin
                    r_car_cnt <= r_car_cnt + CC_W'(1);
                end
            end else begin
                r_car_cnt   <= '0;
                r_car_phase <= 1'b1;
            end

            // Unit timing restarts at every state boundary.
            if (r_state == S_IDLE) begin
                r_unit_cyc <= '0;
                r_units    <= '0;
            end else if (w_tick) begin
                r_unit_cyc <= '0;
                r_units    <= (r_units == w_last_idx) ? '0 : r_units + UN_W'(1);
            end else begin
                r_unit_cyc <= r_unit_cyc + UC_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_START;
                        r_bit_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_state_end) r_state <= S_SPACE;
                end
                S_SPACE: begin
                    if (w_state_end) begin
                        if (r_bit_cnt == BC_W'(N)) begin
                            r_state <= S_GAP;
                        end else begin
                            r_bit   <= i_sr_sout;
                            r_state <= S_MARK;
                        end
                    end
                end
                S_MARK: begin
                    if (w_state_end) begin
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        r_state   <= S_SPACE;
                    end
                end
                S_GAP: begin
                    if (w_state_end) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_frame_encoder.sv
// Testbench for ir_frame_encoder: a behavioural shift register feeds i_sr_sout,
// and a per-cycle expected-output queue is filled from each requested frame.
module tb_ir_frame_encoder;

    localparam int unsigned N   = 4;
    localparam int unsigned UC  = 4;
    localparam int unsigned CH  = 1;
    localparam int unsigned GAP = 2;

    logic         i_clk;
    logic         i_reset_n;
    logic         i_start;
    logic [N-1:0] i_code;
    logic         i_sr_sout;
    logic [N-1:0] o_sr_pin;
    logic         o_sr_load;
    logic         o_sr_enable;
    logic         o_envelope;
    logic         o_ir;
    logic         o_busy;
    logic         o_done;

    typedef struct packed {
        logic env;
        logic ir;
        logic busy;
        logic done;
        logic ld;
        logic en;
    } sig_t;

    sig_t         q_exp[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [N-1:0] sr;

    ir_frame_encoder #(
        .N(N), .UNIT_CYCLES(UC), .CARRIER_HALF(CH), .GAP_UNITS(GAP)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_code(i_code),
        .i_sr_sout(i_sr_sout), .o_sr_pin(o_sr_pin), .o_sr_load(o_sr_load),
        .o_sr_enable(o_sr_enable), .o_envelope(o_envelope), .o_ir(o_ir),
        .o_busy(o_busy), .o_done(o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Shift register model sharing the reset; serial input tied to 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) sr <= '0;
        else if (o_sr_enable) sr <= o_sr_load ? o_sr_pin : {sr[N-2:0], 1'b0};
    end
    assign i_sr_sout = sr[N-1];

    function automatic sig_t mk(logic env, logic ir, logic busy, logic done, logic ld, logic en);
        sig_t s;
        s.env = env; s.ir = ir; s.busy = busy; s.done = done; s.ld = ld; s.en = en;
        return s;
    endfunction

    // Expected cycles from the acceptance cycle through the last gap cycle.
    function automatic void push_frame(logic [N-1:0] code, logic done_first);
        q_exp.push_back(mk(1'b0, 1'b0, 1'b0, done_first, 1'b1, 1'b1));
        for (int i = 0; i < int'(4 * UC); i++)
            q_exp.push_back(mk(1'b1, ((i / CH) % 2) == 0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int b = N - 1; b >= 0; b--) begin
            for (int i = 0; i < int'(UC); i++)
                q_exp.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, i == int'(UC) - 1));
            for (int i = 0; i < (code[b] ? 2 : 1) * int'(UC); i++)
                q_exp.push_back(mk(1'b1, ((i / CH) % 2) == 0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        for (int i = 0; i < int'((1 + GAP) * UC); i++)
            q_exp.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    endfunction

    // Sample outputs mid-cycle and pop the matching expected entry.
    task automatic capture(output sig_t obs, output sig_t exp_s);
        @(negedge i_clk);
        obs = {o_envelope, o_ir, o_busy, o_done, o_sr_load, o_sr_enable};
        if (q_exp.size() > 0) exp_s = q_exp.pop_front();
        else exp_s = '1;
    endtask

    task automatic test_reset();
        logic [N-1:0] exp_pin;
        i_reset_n = 1'b0; i_start = 1'b0; i_code = 4'b0101;
        #2;
        n_tests++; if (o_envelope !== 1'b0) begin n_fail++; $display("FAIL reset_env got %b want 0", o_envelope); end
        n_tests++; if (o_ir !== 1'b0) begin n_fail++; $display("FAIL reset_ir got %b want 0", o_ir); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
        n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_done); end
        n_tests++; if (o_sr_load !== 1'b0) begin n_fail++; $display("FAIL reset_load got %b want 0", o_sr_load); end
        n_tests++; if (o_sr_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got %b want 0", o_sr_enable); end
        exp_pin = 4'b1100;
        i_code  = 4'b1100;
        #1;
        n_tests++; if (o_sr_pin !== exp_pin) begin n_fail++; $display("FAIL reset_sr_pin got %b want %b", o_sr_pin, exp_pin); end
        repeat (2) @(posedge i_clk);
        #3 i_reset_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    // One pulsed-start frame checked cycle by cycle, plus aggregate counts.
    task automatic test_single_frame(input logic [N-1:0] code);
        sig_t o, e, fo, fe;
        int n, mism, first, busy_cnt, en_cnt, ld_cnt, start_ir, ir_out;
        int exp_busy;
        mism = 0; first = 0; busy_cnt = 0; en_cnt = 0; ld_cnt = 0; start_ir = 0; ir_out = 0;
        fo = '0; fe = '0;
        exp_busy = int'(UC) * (4 + 1 + int'(N) + $countones(code) + int'(N) + int'(GAP));
        i_code = code;
        push_frame(code, 1'b0);
        q_exp.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        n = q_exp.size();
        i_start = 1'b1;
        for (int k = 0; k < n; k++) begin
            capture(o, e);
            if (o !== e) begin
                if (mism == 0) begin first = k; fo = o; fe = e; end
                mism++;
            end
            busy_cnt += int'(o.busy);
            en_cnt   += int'(o.en);
            ld_cnt   += int'(o.ld);
            if (k >= 1 && k <= int'(4 * UC)) start_ir += int'(o.ir);
            if (o.ir && !o.env) ir_out++;
            @(posedge i_clk); #1;
            i_start = 1'b0;
        end
        n_tests++; if (mism != 0) begin n_fail++;
            $display("FAIL frame_stream code=%b: %0d bad cycles, first at %0d got %b want %b (env,ir,busy,done,ld,en)",
                     code, mism, first, fo, fe); end
        n_tests++; if (busy_cnt != exp_busy) begin n_fail++; $display("FAIL busy_len code=%b got %0d want %0d", code, busy_cnt, exp_busy); end
        n_tests++; if (en_cnt != int'(N) + 1) begin n_fail++; $display("FAIL enable_count code=%b got %0d want %0d", code, en_cnt, N + 1); end
        n_tests++; if (ld_cnt != 1) begin n_fail++; $display("FAIL load_count code=%b got %0d want 1", code, ld_cnt); end
        n_tests++; if (start_ir != int'(2 * UC / CH)) begin n_fail++; $display("FAIL start_pulses code=%b got %0d want %0d", code, start_ir, 2 * UC / CH); end
        n_tests++; if (ir_out != 0) begin n_fail++; $display("FAIL ir_outside_mark code=%b got %0d cycles want 0", code, ir_out); end
    endtask

    task automatic test_carrier();
        test_single_frame(4'b0110);
    endtask

    // Start held high: frames chain through the done cycle; code edits mid-frame are ignored.
    task automatic test_back_to_back();
        sig_t o, e, fo, fe;
        int n, mism, first, done_cnt, busy_cnt, exp_busy;
        mism = 0; first = 0; done_cnt = 0; busy_cnt = 0; fo = '0; fe = '0;
        exp_busy = 2 * int'(UC) * (4 + 1 + 2 * int'(N) + int'(N) + int'(GAP));
        i_code = 4'b1111; i_start = 1'b1;
        push_frame(4'b1111, 1'b0);
        push_frame(4'b1111, 1'b1);
        q_exp.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        n = q_exp.size();
        for (int k = 0; k < n; k++) begin
            capture(o, e);
            if (o !== e) begin
                if (mism == 0) begin first = k; fo = o; fe = e; end
                mism++;
            end
            done_cnt += int'(o.done);
            busy_cnt += int'(o.busy);
            @(posedge i_clk); #1;
            if (k == 20) i_code = 4'b0000;
            if (k == 60) i_code = 4'b1111;
            if (k == 110) begin i_code = 4'b0000; i_start = 1'b0; end
        end
        i_start = 1'b0;
        n_tests++; if (mism != 0) begin n_fail++;
            $display("FAIL b2b_stream: %0d bad cycles, first at %0d got %b want %b (env,ir,busy,done,ld,en)",
                     mism, first, fo, fe); end
        n_tests++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
        n_tests++; if (busy_cnt != exp_busy) begin n_fail++; $display("FAIL b2b_busy_len got %0d want %0d", busy_cnt, exp_busy); end
    endtask

    // Reset asserted inside the second data mark, then a clean frame afterwards.
    task automatic test_reset_mid();
        sig_t o, e;
        int mism;
        mism = 0;
        i_code = 4'b1010;
        push_frame(4'b1010, 1'b0);
        i_start = 1'b1;
        for (int k = 0; k < 34; k++) begin
            capture(o, e);
            if (o !== e) mism++;
            @(posedge i_clk); #1;
            i_start = 1'b0;
        end
        n_tests++; if (mism != 0) begin n_fail++; $display("FAIL pre_reset_stream got %0d bad cycles want 0", mism); end
        n_tests++; if (o_envelope !== 1'b1) begin n_fail++; $display("FAIL in_mark_before_reset env got %b want 1", o_envelope); end
        #2 i_reset_n = 1'b0;
        #1;
        n_tests++; if (o_envelope !== 1'b0) begin n_fail++; $display("FAIL midreset_env got %b want 0", o_envelope); end
        n_tests++; if (o_ir !== 1'b0) begin n_fail++; $display("FAIL midreset_ir got %b want 0", o_ir); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", o_busy); end
        n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %b want 0", o_done); end
        n_tests++; if (o_sr_enable !== 1'b0) begin n_fail++; $display("FAIL midreset_enable got %b want 0", o_sr_enable); end
        q_exp.delete();
        @(posedge i_clk);
        #3 i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        test_single_frame(4'b1010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame(4'b1010);
        test_single_frame(4'b0000);
        test_carrier();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
